sma_in_capture_ctrl: RTL and testbench

Timing-capture controller for the single-bit SMA input on the DE2-115 web-server Qsys system. It synchronizes the SMA pin, detects selected edges, measures period and high time in `clk` cycles, and counts edges. It raises an interrupt on capture. It sits behind an Avalon-MM slave port as a drop-in enhancement of the plain SMA input PIO; register 0 reads the same way that PIO does.

---
 rtl/sma_in_capture_pkg.sv | 28 ++
 rtl/sma_in_capture_ctrl_if.sv | 20 ++
 rtl/sma_in_sync_edge.sv | 47 ++++
 rtl/sma_in_capture_ctrl.sv | 140 ++++++++++++++
 tb/tb_sma_in_capture_ctrl.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sma_in_capture_pkg.sv
// Shared constants and FSM state type for the SMA input capture controller.
package sma_in_capture_pkg;

  localparam logic [2:0] ADDR_DATA       = 3'd0;
  localparam logic [2:0] ADDR_CONTROL    = 3'd1;
  localparam logic [2:0] ADDR_STATUS     = 3'd2;
  localparam logic [2:0] ADDR_PERIOD     = 3'd3;
  localparam logic [2:0] ADDR_HIGH_TIME  = 3'd4;
  localparam logic [2:0] ADDR_EDGE_COUNT = 3'd5;

  localparam int unsigned CTRL_EN      = 0;
  localparam int unsigned CTRL_RISE    = 1;
  localparam int unsigned CTRL_FALL    = 2;
  localparam int unsigned CTRL_IRQ_EN  = 3;
  localparam int unsigned CTRL_ONESHOT = 4;
  localparam int unsigned CTRL_W       = 5;

  localparam int unsigned STAT_CAP = 0;
  localparam int unsigned STAT_OVF = 1;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEAS,
    DONE
  } state_t;

endpackage

// File: rtl/sma_in_capture_ctrl_if.sv
// Avalon-MM slave bus bundle for the SMA input capture controller.
interface sma_in_capture_ctrl_if;

  logic [2:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, read, write, writedata,
    input  readdata
  );

  modport slave (
    input  address, read, write, writedata,
    output readdata
  );

endinterface

// File: rtl/sma_in_sync_edge.sv
// Pin synchronizer with rise/fall pulse generation.
// Define SMA_IN_GLITCH_FILTER_EN to insert a 3-sample consistency filter.
module sma_in_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic in_port,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   raw;
  logic                   level_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync <= '0;
    else       sync <= {sync[SYNC_STAGES-2:0], in_port};
  end

  assign raw = sync[SYNC_STAGES-1];

`ifdef SMA_IN_GLITCH_FILTER_EN
  logic [1:0] hist;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) hist <= '0;
    else       hist <= {hist[0], raw};
  end

  // Follow the pin only once the current and two previous samples agree.
  assign level = ((raw == hist[0]) && (raw == hist[1])) ? raw : level_q;
`else
  assign level = raw;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) level_q <= 1'b0;
    else       level_q <= level;
  end

  assign rise = level & ~level_q;
  assign fall = ~level & level_q;

endmodule

// File: rtl/sma_in_capture_ctrl.sv
// SMA input timing-capture controller: period, high time and edge count behind Avalon-MM.
// Define SMA_IN_GLITCH_FILTER_EN to enable the input glitch filter in sma_in_sync_edge.
module sma_in_capture_ctrl
  import sma_in_capture_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  sma_in_capture_ctrl_if.slave avs,
  input  logic                 in_port,
  output logic                 irq
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_NEAR = CNT_MAX - CNT_ONE;

  logic              level, rise, fall;
  logic [CTRL_W-1:0] ctrl;
  logic              cap, ovf;
  logic [CNT_W-1:0]  pcnt, hcnt, period, high_time, edge_count;
  state_t            state, state_nxt;
  logic              wr_ctrl, wr_status, wr_edges;
  logic              sel_edge, active, capture, pcnt_sat, hcnt_sat, ovf_set;
  logic              unused_wd;

  sma_in_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_edge (
    .clk    (clk),
    .reset  (reset),
    .in_port(in_port),
    .level  (level),
    .rise   (rise),
    .fall   (fall)
  );

  assign unused_wd = ^avs.writedata[31:CTRL_W];

  always_comb begin
    wr_ctrl   = avs.write && (avs.address == ADDR_CONTROL);
    wr_status = avs.write && (avs.address == ADDR_STATUS);
    wr_edges  = avs.write && (avs.address == ADDR_EDGE_COUNT);
    sel_edge  = (rise && ctrl[CTRL_RISE]) || (fall && ctrl[CTRL_FALL]);
    active    = (state == ARM) || (state == MEAS);
    capture   = (state == MEAS) && sel_edge;
    pcnt_sat  = (pcnt == CNT_MAX);
    hcnt_sat  = (hcnt == CNT_MAX);
    // Flag the cycle a counter steps onto its saturation value.
    ovf_set   = ((state == MEAS) && !sel_edge && (pcnt == CNT_NEAR)) ||
                (active && !rise && level && (hcnt == CNT_NEAR));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!ctrl[CTRL_EN]) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    state_nxt = ARM;
        ARM:     if (sel_edge) state_nxt = MEAS;
        MEAS:    if (sel_edge && ctrl[CTRL_ONESHOT]) state_nxt = DONE;
        DONE:    if (wr_ctrl && avs.writedata[CTRL_EN]) state_nxt = ARM;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt <= '0;
      hcnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          pcnt <= '0;
          hcnt <= '0;
        end
        ARM, MEAS: begin
          if (sel_edge)                           pcnt <= '0;
          else if ((state == MEAS) && !pcnt_sat)  pcnt <= pcnt + CNT_ONE;
          if (rise)                               hcnt <= '0;
          else if (level && !hcnt_sat)            hcnt <= hcnt + CNT_ONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period     <= '0;
      high_time  <= '0;
      edge_count <= '0;
    end else begin
      if (capture) period <= pcnt_sat ? CNT_MAX : pcnt + CNT_ONE;
      if (active && fall) high_time <= hcnt_sat ? CNT_MAX : hcnt + CNT_ONE;
      if (wr_edges)                                edge_count <= '0;
      else if (capture && (edge_count != CNT_MAX)) edge_count <= edge_count + CNT_ONE;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl <= '0;
      cap  <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      if (wr_ctrl) ctrl <= avs.writedata[CTRL_W-1:0];
      cap <= capture || (cap && !(wr_status && avs.writedata[STAT_CAP]));
      ovf <= ovf_set || (ovf && !(wr_status && avs.writedata[STAT_OVF]));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      avs.readdata <= '0;
    end else if (avs.read) begin
      case (avs.address)
        ADDR_DATA:       avs.readdata <= {31'b0, level};
        ADDR_CONTROL:    avs.readdata <= {27'b0, ctrl};
        ADDR_STATUS:     avs.readdata <= {30'b0, ovf, cap};
        ADDR_PERIOD:     avs.readdata <= 32'(period);
        ADDR_HIGH_TIME:  avs.readdata <= 32'(high_time);
        ADDR_EDGE_COUNT: avs.readdata <= 32'(edge_count);
        default:         avs.readdata <= '0;
      endcase
    end
  end

  assign irq = ctrl[CTRL_IRQ_EN] & cap;

endmodule

// File: tb/tb_sma_in_capture_ctrl.sv
// Self-checking bench for sma_in_capture_ctrl: directed scenarios plus randomized traffic.
module tb_sma_in_capture_ctrl;

  localparam int unsigned SYNC = 2;
  localparam int unsigned CW   = 8;
  localparam int          MAXV = (1 << CW) - 1;

  localparam int M_IDLE = 0;
  localparam int M_ARM  = 1;
  localparam int M_MEAS = 2;
  localparam int M_DONE = 3;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_port;
  logic irq;

  sma_in_capture_ctrl_if bus ();

  sma_in_capture_ctrl #(
    .SYNC_STAGES(SYNC),
    .CNT_W      (CW)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .avs    (bus.slave),
    .in_port(in_port),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit checking = 0;
  int run;
  int op;

  // Reference model state: cycle stamps and unbounded counts, clamped on capture.
  int       m_mode;
  bit [4:0] m_ctrl;
  bit       m_cap, m_ovf, m_fq;
  int       m_period, m_high, m_edges;
  int       m_cyc, m_tstart, m_hacc;
  bit [31:0] m_rd;
  bit       samp[$];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
  endfunction

  function automatic int clampv(input int v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  task automatic model_reset();
    m_mode = M_IDLE; m_ctrl = '0; m_cap = 0; m_ovf = 0; m_fq = 0;
    m_period = 0; m_high = 0; m_edges = 0;
    m_cyc = 0; m_tstart = 0; m_hacc = 0; m_rd = '0;
    samp.delete();
    repeat (SYNC + 2) samp.push_back(1'b0);
  endtask

  task automatic model_step();
    bit f, l0, rise, fall, sel, cap_set, ovf_set, inc;
    bit wr, rd;
    bit [2:0] a;
    bit [31:0] wd;
    int n, nmode;
    n  = samp.size();
    l0 = samp[n-SYNC];
`ifdef SMA_IN_GLITCH_FILTER_EN
    f = ((l0 == samp[n-SYNC-1]) && (l0 == samp[n-SYNC-2])) ? l0 : m_fq;
`else
    f = l0;
`endif
    rise = f & ~m_fq;
    fall = ~f & m_fq;
    sel  = (rise & m_ctrl[1]) | (fall & m_ctrl[2]);
    wr = bus.write; rd = bus.read; a = bus.address; wd = bus.writedata;

    if (rd) begin
      case (a)
        3'd0: m_rd = {31'b0, f};
        3'd1: m_rd = {27'b0, m_ctrl};
        3'd2: m_rd = {30'b0, m_ovf, m_cap};
        3'd3: m_rd = 32'(m_period);
        3'd4: m_rd = 32'(m_high);
        3'd5: m_rd = 32'(m_edges);
        default: m_rd = '0;
      endcase
    end

    cap_set = 0; ovf_set = 0; inc = 0; nmode = m_mode;
    case (m_mode)
      M_ARM: if (sel) begin m_tstart = m_cyc; nmode = M_MEAS; end
      M_MEAS: begin
        if (sel) begin
          m_period = clampv(m_cyc - m_tstart);
          m_tstart = m_cyc;
          cap_set = 1; inc = 1;
          if (m_ctrl[4]) nmode = M_DONE;
        end else if (m_cyc - m_tstart == MAXV) begin
          ovf_set = 1;
        end
      end
      M_DONE: if (wr && a == 3'd1 && wd[0]) nmode = M_ARM;
      default: nmode = M_ARM;
    endcase
    if (!m_ctrl[0]) nmode = M_IDLE;

    if (m_mode == M_ARM || m_mode == M_MEAS) begin
      if (rise) m_hacc = 0;
      else if (f) begin
        m_hacc++;
        if (m_hacc == MAXV) ovf_set = 1;
      end
      if (fall) m_high = clampv(m_hacc + 1);
    end else if (m_mode == M_IDLE) begin
      m_hacc = 0;
    end

    if (wr && a == 3'd5) m_edges = 0;
    else if (inc && m_edges < MAXV) m_edges++;
    m_cap = cap_set | (m_cap & ~(wr && a == 3'd2 && wd[0]));
    m_ovf = ovf_set | (m_ovf & ~(wr && a == 3'd2 && wd[1]));
    if (wr && a == 3'd1) m_ctrl = wd[4:0];

    m_mode = nmode;
    m_fq = f;
    samp.push_back(in_port);
    if (samp.size() > 8) void'(samp.pop_front());
    m_cyc++;
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) model_reset();
    else       model_step();
  end

  always @(negedge clk) begin
    if (checking) begin
      chk("irq", {31'b0, irq}, {31'b0, m_ctrl[3] & m_cap});
      chk("readdata", bus.readdata, m_rd);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bwrite(input logic [2:0] a, input logic [31:0] d);
    bus.address = a; bus.writedata = d; bus.write = 1'b1;
    tick();
    bus.write = 1'b0;
  endtask

  task automatic bread_expect(input logic [2:0] a, input logic [31:0] exp, input string nm);
    bus.address = a; bus.read = 1'b1;
    tick();
    bus.read = 1'b0;
    chk(nm, bus.readdata, exp);
  endtask

  task automatic pulse(input int hi, input int lo);
    in_port = 1'b1;
    repeat (hi) tick();
    in_port = 1'b0;
    repeat (lo) tick();
  endtask

  initial begin
    bus.address = '0; bus.read = 1'b0; bus.write = 1'b0; bus.writedata = '0;
    in_port = 1'b0;
    #1 reset = 1'b1;
    checking = 1;
    tick(); tick();
    reset = 1'b0;
    tick();
    for (int a = 0; a < 6; a++) bread_expect(3'(a), 32'd0, "reset_readback");
    chk("reset_irq", {31'b0, irq}, 32'd0);

    // Period / high time: 10 high, 10 low, rising edges only, irq enabled.
    bwrite(3'd1, 32'h0B);
    repeat (3) tick();
    pulse(10, 10);
    in_port = 1'b1;
    tick(); tick();
    chk("irq_before_capture", {31'b0, irq}, 32'd0);
    tick();
    chk("irq_at_capture", {31'b0, irq}, 32'd1);
    repeat (7) tick();
    in_port = 1'b0;
    repeat (10) tick();
    pulse(10, 10);
    pulse(10, 10);
    bread_expect(3'd3, 32'd20, "period_20");
    bread_expect(3'd4, 32'd10, "high_time_10");
    bread_expect(3'd5, 32'd3, "edge_count_3");
    chk("model_period_20", 32'(m_period), 32'd20);
    chk("model_high_10", 32'(m_high), 32'd10);
    chk("model_edges_3", 32'(m_edges), 32'd3);

    // Capture and CAP clear land on the same clock edge.
    bwrite(3'd2, 32'h1);
    in_port = 1'b1;
    tick(); tick();
    bus.address = 3'd2; bus.writedata = 32'h1; bus.write = 1'b1;
    tick();
    bus.write = 1'b0;
    bread_expect(3'd2, 32'h1, "w1c_race_cap_kept");
    chk("w1c_race_irq", {31'b0, irq}, 32'd1);
    in_port = 1'b0;
    bwrite(3'd2, 32'h1);
    repeat (4) tick();
    chk("w1c_clear_irq", {31'b0, irq}, 32'd0);
    bread_expect(3'd2, 32'h0, "w1c_clear_cap");

    // One-shot freezes after the first capture; rewriting CONTROL re-arms.
    bwrite(3'd1, 32'h0);
    bwrite(3'd2, 32'h3);
    bwrite(3'd5, 32'h0);
    bwrite(3'd1, 32'h13);
    repeat (3) tick();
    repeat (4) pulse(4, 4);
    bread_expect(3'd3, 32'd8, "oneshot_period_8");
    bread_expect(3'd5, 32'd1, "oneshot_edges_1");
    repeat (3) pulse(6, 6);
    bread_expect(3'd3, 32'd8, "oneshot_frozen");
    bread_expect(3'd5, 32'd1, "oneshot_edges_frozen");
    bwrite(3'd1, 32'h13);
    repeat (3) pulse(6, 6);
    bread_expect(3'd3, 32'd12, "rearm_period_12");
    bread_expect(3'd5, 32'd2, "rearm_edges_2");
    chk("model_rearm_period", 32'(m_period), 32'd12);

    // Overflow: edges 300 cycles apart saturate an 8-bit period.
    bwrite(3'd1, 32'h0);
    bwrite(3'd2, 32'h3);
    bwrite(3'd1, 32'h03);
    repeat (3) tick();
    repeat (3) pulse(5, 295);
    bread_expect(3'd3, 32'd255, "ovf_period_255");
    bread_expect(3'd4, 32'd5, "ovf_high_5");
    bread_expect(3'd2, 32'h3, "ovf_status");
    chk("model_ovf_period", 32'(m_period), 32'd255);

    // Reset while measuring returns everything to zero and idle.
    bwrite(3'd2, 32'h3);
    bwrite(3'd1, 32'h0F);
    repeat (3) pulse(3, 5);
    in_port = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    in_port = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    for (int a = 0; a < 6; a++) bread_expect(3'(a), 32'd0, "midmeas_reset_readback");
    chk("midmeas_reset_irq", {31'b0, irq}, 32'd0);
    repeat (3) pulse(4, 4);
    bread_expect(3'd5, 32'd0, "idle_after_reset_edges");
    bread_expect(3'd2, 32'd0, "idle_after_reset_status");

`ifdef SMA_IN_GLITCH_FILTER_EN
    bwrite(3'd1, 32'h03);
    repeat (3) tick();
    pulse(6, 10);
    pulse(2, 10);
    bread_expect(3'd5, 32'd0, "glitch_rejected");
    pulse(3, 10);
    bread_expect(3'd5, 32'd1, "pulse3_accepted");
    bwrite(3'd1, 32'h0);
`endif

    // Randomized traffic against the reference model.
    run = 5;
    for (int i = 0; i < 6000; i++) begin
      if (run == 0) begin
        in_port = ~in_port;
        run = ($urandom_range(0, 15) == 0) ? int'($urandom_range(100, 300)) : int'($urandom_range(1, 24));
      end else begin
        run--;
      end
      op = int'($urandom_range(0, 99));
      if (op < 3) begin
        bus.address = 3'd1; bus.writedata = $urandom;
        if ($urandom_range(0, 3) != 0) bus.writedata[0] = 1'b1;
        bus.write = 1'b1;
      end else if (op < 8) begin
        bus.address = 3'd2; bus.writedata = 32'($urandom_range(0, 3)); bus.write = 1'b1;
      end else if (op == 8) begin
        bus.address = 3'd5; bus.writedata = $urandom; bus.write = 1'b1;
      end else if (op == 9) begin
        case ($urandom_range(0, 4))
          0: bus.address = 3'd0;
          1: bus.address = 3'd3;
          2: bus.address = 3'd4;
          3: bus.address = 3'd6;
          default: bus.address = 3'd7;
        endcase
        bus.writedata = $urandom; bus.write = 1'b1;
      end else if (op < 45) begin
        bus.address = 3'($urandom_range(0, 7)); bus.read = 1'b1;
      end
      tick();
      bus.write = 1'b0;
      bus.read = 1'b0;
    end

    tick();
    checking = 0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
